// File: rtl/tl45_prefetch.sv
// rtl/tl45_prefetch.sv - tl45 instruction fetch unit: single-outstanding memory fetch, prefetch FIFO, decode output register
// Fetch FSM issues one request at a time; redirects discard in-flight data and empty the FIFO.
module tl45_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pipe_stall,
  input  logic        i_pipe_flush,
  input  logic        i_new_pc,
  input  logic [31:0] i_pc,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_data,
  input  logic        i_mem_err,
  output logic        o_buf_valid,
  output logic [31:0] o_buf_pc,
  output logic [31:0] o_buf_inst,
  output logic        o_buf_err
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [31:0] RESET_ADDR = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DRAIN, ST_HALT} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   w_fetch_pc_next;
  logic          r_mem_req;
  logic [31:0]   r_mem_addr;

  logic [31:0]   r_fifo_pc   [DEPTH];
  logic [31:0]   r_fifo_inst [DEPTH];
  logic          r_fifo_err  [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          r_buf_valid;
  logic [31:0]   r_buf_pc;
  logic [31:0]   r_buf_inst;
  logic          r_buf_err;

  logic          w_redirect;
  logic [31:0]   w_target;
  logic          w_full;
  logic          w_empty;
  logic          w_issue;
  logic          w_push;
  logic          w_ack_done;
  logic          w_pop;

  assign w_redirect = i_pipe_flush | i_new_pc;
  assign w_target   = i_new_pc ? {i_pc[31:2], 2'b00} : r_fetch_pc;
  assign w_full     = (r_count == FULL_COUNT);
  assign w_empty    = (r_count == '0);
  assign w_pop      = !w_redirect && !i_pipe_stall && !w_empty;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= RESET_ADDR;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
    end
  end

  // Redirect always retargets fetch_pc; only a clean ack advances it.
  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = w_redirect ? w_target : r_fetch_pc;
    w_issue         = 1'b0;
    w_push          = 1'b0;
    w_ack_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_redirect && !w_full) begin
          w_issue      = 1'b1;
          w_state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_redirect) begin
          w_ack_done   = i_mem_ack;
          w_state_next = i_mem_ack ? ST_IDLE : ST_DRAIN;
        end else if (i_mem_ack) begin
          w_push          = 1'b1;
          w_ack_done      = 1'b1;
          w_fetch_pc_next = r_fetch_pc + 32'd4;
          w_state_next    = i_mem_err ? ST_HALT : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (i_mem_ack) begin
          w_ack_done   = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_HALT: begin
        if (w_redirect) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_ADDR;
    end else if (w_issue) begin
      r_mem_req  <= 1'b1;
      r_mem_addr <= r_fetch_pc;
    end else if (w_ack_done) begin
      r_mem_req  <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]   <= r_fetch_pc;
      r_fifo_inst[r_wr_ptr] <= i_mem_err ? 32'h0 : i_mem_data;
      r_fifo_err[r_wr_ptr]  <= i_mem_err;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || w_redirect) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // An unstalled cycle with nothing to pop presents a bubble of all zeros.
  always_ff @(posedge i_clk) begin
    if (i_reset || w_redirect) begin
      r_buf_valid <= 1'b0;
      r_buf_pc    <= 32'h0;
      r_buf_inst  <= 32'h0;
      r_buf_err   <= 1'b0;
    end else if (!i_pipe_stall) begin
      if (w_pop) begin
        r_buf_valid <= 1'b1;
        r_buf_pc    <= r_fifo_pc[r_rd_ptr];
        r_buf_inst  <= r_fifo_inst[r_rd_ptr];
        r_buf_err   <= r_fifo_err[r_rd_ptr];
      end else begin
        r_buf_valid <= 1'b0;
        r_buf_pc    <= 32'h0;
        r_buf_inst  <= 32'h0;
        r_buf_err   <= 1'b0;
      end
    end
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_addr  = r_mem_addr;
  assign o_buf_valid = r_buf_valid;
  assign o_buf_pc    = r_buf_pc;
  assign o_buf_inst  = r_buf_inst;
  assign o_buf_err   = r_buf_err;

endmodule

// File: tb/tb_tl45_prefetch.sv
// tb/tb_tl45_prefetch.sv - directed scoreboard bench for tl45_prefetch
module tb_tl45_prefetch;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pipe_stall = 1'b0;
  logic        pipe_flush = 1'b0;
  logic        new_pc = 1'b0;
  logic [31:0] pc_in = 32'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_data = 32'h0;
  logic        mem_err = 1'b0;
  logic        buf_valid;
  logic [31:0] buf_pc;
  logic [31:0] buf_inst;
  logic        buf_err;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] req_log[$];
  int          total = 0;
  int          bad = 0;
  int          ack_delay = 0;
  int          mem_wait = 0;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = 32'h0;
  logic        mon_en = 1'b0;
  logic        last_stall = 1'b0;
  logic        prev_req = 1'b0;
  int          n;

  tl45_prefetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_pipe_stall (pipe_stall),
    .i_pipe_flush (pipe_flush),
    .i_new_pc     (new_pc),
    .i_pc         (pc_in),
    .o_mem_req    (mem_req),
    .o_mem_addr   (mem_addr),
    .i_mem_ack    (mem_ack),
    .i_mem_data   (mem_data),
    .i_mem_err    (mem_err),
    .o_buf_valid  (buf_valid),
    .o_buf_pc     (buf_pc),
    .o_buf_inst   (buf_inst),
    .o_buf_err    (buf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  function automatic void push_exp(input logic [31:0] pc, input logic err);
    exp_t e;
    e.pc   = pc;
    e.inst = err ? 32'h0 : (pc ^ 32'hA5A5_0000);
    e.err  = err;
    exp_q.push_back(e);
  endfunction

  function automatic logic [31:0] log_at(input int i);
    return (req_log.size() > i) ? req_log[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 32'(buf_valid), 32'd0);
    chk({tag, "_pc"}, buf_pc, 32'd0);
    chk({tag, "_inst"}, buf_inst, 32'd0);
    chk({tag, "_err"}, 32'(buf_err), 32'd0);
    chk({tag, "_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_addr"}, mem_addr, 32'd0);
  endtask

  task automatic drain_exp(input string tag, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      cyc();
      k++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Memory model: ack after ack_delay idle cycles, data = addr ^ A5A5_0000.
  always @(negedge clk) begin
    mem_ack  = 1'b0;
    mem_data = 32'h0;
    mem_err  = 1'b0;
    if (mem_req === 1'b1 && !reset) begin
      if (mem_wait >= ack_delay) begin
        mem_ack  = 1'b1;
        mem_data = mem_addr ^ 32'hA5A5_0000;
        mem_err  = err_en && (mem_addr == err_addr);
        mem_wait = 0;
      end else begin
        mem_wait++;
      end
    end else begin
      mem_wait = 0;
    end
  end

  always @(negedge clk) begin
    if (mem_req === 1'b1 && prev_req !== 1'b1) begin
      req_log.push_back(mem_addr);
    end
    prev_req = mem_req;
  end

  always @(posedge clk) last_stall <= pipe_stall;

  always @(negedge clk) begin
    if (mon_en) begin
      if (buf_valid === 1'b1 && !last_stall) begin
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_out observed pc=%h expected no output", buf_pc);
        end
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("out_pc", buf_pc, mon_e.pc);
          chk("out_inst", buf_inst, mon_e.inst);
          chk("out_err", 32'(buf_err), 32'(mon_e.err));
        end
      end else if (buf_valid !== 1'b1) begin
        chk("bubble_zero", buf_pc | buf_inst | 32'(buf_err), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic streaming, ack one cycle after each request.
    repeat (3) cyc();
    chk_reset("reset_state");
    mon_en = 1'b1;
    reset = 1'b0;
    req_log.delete();
    push_exp(32'h0, 1'b0);
    push_exp(32'h4, 1'b0);
    push_exp(32'h8, 1'b0);
    push_exp(32'hC, 1'b0);
    cyc();
    chk("p1_req_first", 32'(mem_req), 32'd1);
    chk("p1_addr_first", mem_addr, 32'h0);
    chk("p1_valid_e1", 32'(buf_valid), 32'd0);
    cyc();
    chk("p1_valid_e2", 32'(buf_valid), 32'd0);
    cyc();
    chk("p1_valid_e3", 32'(buf_valid), 32'd1);
    cyc();
    chk("p1_valid_e4", 32'(buf_valid), 32'd0);
    cyc();
    chk("p1_valid_e5", 32'(buf_valid), 32'd1);
    drain_exp("p1_drain", 20);
    pipe_stall = 1'b1;

    // Stall fills the FIFO; release streams it out back to back.
    reset = 1'b1;
    cyc();
    chk_reset("p2_reset");
    reset = 1'b0;
    req_log.delete();
    repeat (20) cyc();
    chk("p2_req_count", 32'(req_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("p2_req_addr", log_at(i), 32'(4 * i));
    chk("p2_req_idle", 32'(mem_req), 32'd0);
    push_exp(32'h0, 1'b0);
    push_exp(32'h4, 1'b0);
    push_exp(32'h8, 1'b0);
    push_exp(32'hC, 1'b0);
    push_exp(32'h10, 1'b0);
    pipe_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("p2_consec_valid", 32'(buf_valid), 32'd1);
    end
    drain_exp("p2_drain", 20);
    pipe_stall = 1'b1;
    chk("p2_resume_addr", log_at(4), 32'h10);

    // Redirect while a slow request is outstanding.
    reset = 1'b1;
    cyc();
    chk_reset("p3_reset");
    reset = 1'b0;
    pipe_stall = 1'b0;
    ack_delay = 3;
    push_exp(32'h0, 1'b0);
    push_exp(32'h4, 1'b0);
    push_exp(32'h100, 1'b0);
    push_exp(32'h104, 1'b0);
    n = 0;
    while (!(mem_req === 1'b1 && mem_addr == 32'h8) && n < 40) begin
      cyc();
      n++;
    end
    chk("p3_busy_addr8", mem_addr, 32'h8);
    new_pc = 1'b1;
    pc_in = 32'h103;
    cyc();
    new_pc = 1'b0;
    chk("p3_out_cleared", 32'(buf_valid), 32'd0);
    chk("p3_req_held", 32'(mem_req), 32'd1);
    n = 0;
    while (mem_req === 1'b1 && n < 10) begin
      chk("p3_addr_hold", mem_addr, 32'h8);
      cyc();
      n++;
    end
    chk("p3_drained", 32'(mem_req), 32'd0);
    cyc();
    chk("p3_next_req", 32'(mem_req), 32'd1);
    chk("p3_next_addr", mem_addr, 32'h100);
    drain_exp("p3_drain", 60);
    pipe_stall = 1'b1;

    // Redirect in the same cycle as the ack.
    reset = 1'b1;
    cyc();
    chk_reset("p4_reset");
    reset = 1'b0;
    pipe_stall = 1'b0;
    ack_delay = 0;
    push_exp(32'h0, 1'b0);
    push_exp(32'h200, 1'b0);
    push_exp(32'h204, 1'b0);
    n = 0;
    while (!(mem_req === 1'b1 && mem_addr == 32'h4 && mem_ack) && n < 20) begin
      cyc();
      n++;
    end
    chk("p4_ack_addr4", 32'(mem_ack), 32'd1);
    new_pc = 1'b1;
    pc_in = 32'h200;
    cyc();
    new_pc = 1'b0;
    chk("p4_req_dropped", 32'(mem_req), 32'd0);
    chk("p4_out_cleared", 32'(buf_valid), 32'd0);
    cyc();
    chk("p4_next_req", 32'(mem_req), 32'd1);
    chk("p4_next_addr", mem_addr, 32'h200);
    drain_exp("p4_drain", 30);
    pipe_stall = 1'b1;

    // Bus error halts fetch until a redirect.
    reset = 1'b1;
    cyc();
    chk_reset("p5_reset");
    reset = 1'b0;
    pipe_stall = 1'b0;
    err_en = 1'b1;
    err_addr = 32'h4;
    req_log.delete();
    push_exp(32'h0, 1'b0);
    push_exp(32'h4, 1'b1);
    drain_exp("p5_drain", 20);
    chk("p5_err_flag", 32'(buf_err), 32'd1);
    repeat (12) cyc();
    chk("p5_req_count", 32'(req_log.size()), 32'd2);
    chk("p5_no_req", 32'(mem_req), 32'd0);
    err_en = 1'b0;
    push_exp(32'h0, 1'b0);
    push_exp(32'h4, 1'b0);
    push_exp(32'h8, 1'b0);
    new_pc = 1'b1;
    pc_in = 32'h0;
    cyc();
    new_pc = 1'b0;
    cyc();
    chk("p5_restart_req", 32'(mem_req), 32'd1);
    chk("p5_restart_addr", mem_addr, 32'h0);
    drain_exp("p5_restart_drain", 30);
    pipe_stall = 1'b1;

    // Reset while draining a flushed request.
    reset = 1'b1;
    cyc();
    chk_reset("p6_reset");
    reset = 1'b0;
    pipe_stall = 1'b0;
    ack_delay = 3;
    cyc();
    chk("p6_req", 32'(mem_req), 32'd1);
    pipe_flush = 1'b1;
    cyc();
    pipe_flush = 1'b0;
    chk("p6_drain_req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    cyc();
    chk_reset("p6_reset_drain");
    reset = 1'b0;
    cyc();
    chk("p6_req_after", 32'(mem_req), 32'd1);
    chk("p6_addr_after", mem_addr, 32'h0);
    chk("p6_exp_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tl45_prefetch.md
Name: tl45_prefetch

Overview:
Parametrised instruction fetch unit for the tl45 core. It replaces the hard-wired instruction table with real memory fetch over a single-outstanding req/ack bus and buffers instructions in a DEPTH-entry prefetch FIFO. It feeds the decode stage through a registered pc/inst/valid/err output that honours pipeline stall, flush and PC redirect. It sits between the instruction memory port and decode.

Parameters:
DEPTH, 4, prefetch FIFO entries; power of 2, minimum 2.
RESET_PC, 32'h0, fetch address after reset; bits [1:0] must be 0.

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_pipe_stall  in  1  decode not accepting; output register holds
i_pipe_flush  in  1  discard all fetched/in-flight instructions
i_new_pc  in  1  redirect fetch to i_pc; also acts as flush
i_pc  in  32  redirect target; bits [1:0] ignored (forced 0)
o_mem_req  out  1  fetch request; held until i_mem_ack
o_mem_addr  out  32  word-aligned fetch address; stable while o_mem_req=1
i_mem_ack  in  1  response valid, sampled at clock edge
i_mem_data  in  32  instruction word, valid with i_mem_ack
i_mem_err  in  1  bus error, valid with i_mem_ack
o_buf_valid  out  1  o_buf_pc/o_buf_inst hold a real instruction
o_buf_pc  out  32  PC of the presented instruction
o_buf_inst  out  32  instruction word (0 when invalid or errored)
o_buf_err  out  1  presented entry is a fetch fault

Behaviour:
- Reset: fetch_pc=RESET_PC; FIFO empty; state IDLE; o_mem_req=0, o_mem_addr=RESET_PC; o_buf_valid=0, o_buf_pc=0, o_buf_inst=0, o_buf_err=0. Reset overrides every other input.
- Redirect = i_pipe_flush | i_new_pc. Target = i_new_pc ? {i_pc[31:2],2'b00} : fetch_pc.
- FSM states: IDLE, BUSY, DRAIN, HALT.
- IDLE: if no redirect and (fifo_count < DEPTH), set o_mem_req=1, o_mem_addr=fetch_pc -> BUSY.
- BUSY: on i_mem_ack without redirect, push {fetch_pc, data, err}; fetch_pc += 4.
  - err=1: push inst=0, err=1 -> HALT.
  - err=0: -> IDLE.
  - Ack drops o_mem_req at the same edge.
  - fetch_pc wraps 32'hFFFFFFFC -> 0.
- BUSY + redirect, no ack in the same cycle: -> DRAIN. o_mem_req and o_mem_addr are held; fetch_pc=target.
- BUSY + redirect + ack in the same cycle: response discarded; fetch_pc=target -> IDLE.
- DRAIN: wait for i_mem_ack, discard it -> IDLE. A further redirect while in DRAIN updates fetch_pc, state stays DRAIN.
- HALT: no requests. A redirect sets fetch_pc=target -> IDLE.
- Request issue is suppressed in any cycle a redirect is present.
- Max one outstanding request. The FIFO cannot overflow: a request issues only when count < DEPTH, and count cannot grow while the request is outstanding.
- Output stage, checked in priority order:
  - Redirect: o_buf_valid/pc/inst/err cleared to 0. FIFO emptied at the same edge (count=0, pointers reset).
  - Else if !i_pipe_stall and FIFO non-empty: pop head into the output register with o_buf_valid=1.
  - Else if !i_pipe_stall and FIFO empty: output register = all zeros (bubble).
  - Else (i_pipe_stall): output holds.
- Push and pop in the same cycle are both legal; count is unchanged.
- Latency: ack at edge N writes the FIFO; the instruction appears on o_buf_* after edge N+1, provided the pipe is unstalled.
- o_buf_pc/o_buf_inst are always 0 when o_buf_valid=0.

Test Plan:
- Reset, memory ack 1 cycle after each req, data=addr^32'hA5A5_0000, no stall -> o_buf_pc sequence 0,4,8,C with matching inst; o_buf_valid=1 every other cycle; first valid 3 cycles after reset release.
- Hold i_pipe_stall=1 for 20 cycles with DEPTH=4 -> exactly 4 requests issued (0..C), then o_mem_req stays 0. Release stall -> outputs 0,4,8,C on consecutive cycles, then fetch resumes at 32'h10.
- Assert i_new_pc=1, i_pc=32'h103 while BUSY on addr 8 with ack delayed 3 cycles -> o_mem_addr stays 8 until ack; ack data is discarded; output cleared; next request addr=32'h100; first valid o_buf_pc=32'h100.
- Redirect in the same cycle as ack -> that data never appears at the output; next o_mem_addr=target.
- i_mem_err=1 on the ack for addr 4 -> o_buf_valid=1, o_buf_err=1, o_buf_pc=4, inst=0; no further requests. Then i_new_pc with i_pc=0 -> fetching restarts at 0.
- i_reset asserted while DRAIN or FIFO full -> all outputs zero next cycle; o_mem_req=0 for one cycle, then request to RESET_PC.
